regfile_nrw_bypass: RTL and testbench
=====================================

// Module: regfile_nrw_bypass
// PURPOSE
//  Parametrised CPU register file: DEPTH x WIDTH storage, one write port with
//  byte enables, two independent read ports. Optional hardwired-zero entry 0,
//  write-to-read bypass and a registered (1-cycle) read mode.
//  Sits between decode and execute; replaces the fixed 32x32 regfile and
//  32:1 read-mux pair.
// PARAMETERS
//  WIDTH        32  data width in bits; must be a multiple of 8
//  ADDR_BITS    5   address width; DEPTH = 2**ADDR_BITS
//  ZERO_REG     1   1: entry 0 always reads 0 and ignores writes
//  BYPASS       1   1: a same-cycle write to a read address is forwarded to that read port
//  READ_LATENCY 0   0: combinational read; 1: read data registered on clk
// PORTS
//  clk       in   1          single clock, all state updates on posedge
//  reset     in   1          synchronous, active-high
//  we        in   1          write enable
//  wr_addr   in   ADDR_BITS  write address
//  wr_be     in   WIDTH/8    byte enables; bit i covers wr_data[8i+7:8i]
//  wr_data   in   WIDTH      write data
//  rd_addr1  in   ADDR_BITS  read port 1 address
//  rd_data1  out  WIDTH      read port 1 data
//  rd_addr2  in   ADDR_BITS  read port 2 address
//  rd_data2  out  WIDTH      read port 2 data
// BEHAVIOUR
//  - Reset: at a posedge with reset=1, every entry is cleared to 0 and any
//    write that cycle is dropped. Read data registers (LAT=1) are cleared to 0.
//    While reset=1, rd_data1/2 read 0 in both modes; bypass is suppressed.
//  - Write: at a posedge with we=1 and reset=0, entry[wr_addr] byte i takes
//    wr_data byte i where wr_be[i]=1. Other bytes and entries hold.
//    we=1 with wr_be=0 changes nothing.
//  - ZERO_REG=1: writes to address 0 are discarded. Reads of address 0 return 0,
//    including when bypass would otherwise forward.
//  - Forwarded value fwd(a): if BYPASS=1, we=1, reset=0, wr_addr==a and
//    a is not the zero entry: the merged word (new bytes where wr_be=1,
//    stored bytes otherwise). If not, entry[a].
//  - READ_LATENCY=0: rd_dataN = fwd(rd_addrN), combinational, same cycle.
//  - READ_LATENCY=1: rd_dataN loads fwd(rd_addrN) at the posedge. Data is valid
//    the cycle after the address is presented. A read and a write to the same
//    address in one cycle return the new value next cycle, even with BYPASS=0.
//  - BYPASS=0, LAT=0: a same-cycle read returns the old value. The new value is
//    visible from the next cycle.
//  - Both ports may read the same address and are fully independent of each
//    other. Addresses wrap naturally at DEPTH; there are no out-of-range addresses.
//  - Reset mid-stream: a write coincident with reset is lost. The first
//    post-reset reads return 0.
// TESTING
//  1 Reset then read all 32 addrs on both ports -> every rd_data = 0.
//  2 Write 0xDEADBEEF to r5 (be=4'hF), next cycle rd_addr1=5 -> 0xDEADBEEF;
//    rd_addr2=4 -> 0.
//  3 r5=0xDEADBEEF; write 0x11223344 be=4'b0101 -> r5 reads 0xDE22BE44.
//  4 ZERO_REG=1: write 0xFFFFFFFF to r0, same-cycle and next-cycle read r0 -> 0.
//  5 BYPASS=1, LAT=0: write 0xCAFEF00D to r7 while rd_addr1=rd_addr2=7 ->
//    both outputs 0xCAFEF00D in the same cycle.
//    With BYPASS=0 -> old value, then 0xCAFEF00D next cycle.
//  6 LAT=1: write 0x12345678 to r3 with rd_addr1=3, reset=1 coincident ->
//    rd_data1=0 next cycle, r3 reads 0 afterwards.
//    Repeat with reset=0 -> rd_data1=0x12345678 next cycle.

Source files
------------

// File: rtl/regfile_nrw_bypass_if.sv
// Register-file access bundle: one byte-enabled write port and two read ports.
// The master drives the write and read addresses; the slave returns the read data.
interface regfile_nrw_bypass_if #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5
);
    logic                   we;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [WIDTH/8-1:0]     wr_be;
    logic [WIDTH-1:0]       wr_data;
    logic [ADDR_BITS-1:0]   rd_addr1;
    logic [WIDTH-1:0]       rd_data1;
    logic [ADDR_BITS-1:0]   rd_addr2;
    logic [WIDTH-1:0]       rd_data2;

    modport master (
        output we, wr_addr, wr_be, wr_data, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2
    );

    modport slave (
        input  we, wr_addr, wr_be, wr_data, rd_addr1, rd_addr2,
        output rd_data1, rd_data2
    );
endinterface

// File: rtl/regfile_nrw_bypass.sv
// Parametrised register file with byte-enabled writes, two read ports, an optional
// hardwired-zero entry 0, optional write-to-read bypass and optional registered reads.
module regfile_nrw_bypass #(
    parameter int WIDTH        = 32,
    parameter int ADDR_BITS    = 5,
    parameter int ZERO_REG     = 1,
    parameter int BYPASS       = 1,
    parameter int READ_LATENCY = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_nrw_bypass_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int NB    = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] wr_merged;
    logic             wr_ok;
    logic             zero1, zero2;
    logic [WIDTH-1:0] fwd1, fwd2;

    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        wr_merged = merge_bytes(mem_q[bus.wr_addr], bus.wr_data, bus.wr_be);
        wr_ok     = bus.we && !((ZERO_REG != 0) && (bus.wr_addr == '0));
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (wr_ok) mem_d[bus.wr_addr] = wr_merged;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) mem_q[i] <= '0;
            else       mem_q[i] <= mem_d[i];
        end
    end

    // Entry 0 reads as zero even when a bypass hit would otherwise forward.
    always_comb begin
        zero1 = (ZERO_REG != 0) && (bus.rd_addr1 == '0);
        zero2 = (ZERO_REG != 0) && (bus.rd_addr2 == '0);
        fwd1  = mem_q[bus.rd_addr1];
        fwd2  = mem_q[bus.rd_addr2];
        if ((BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr1)) fwd1 = wr_merged;
        if ((BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr2)) fwd2 = wr_merged;
        if (zero1) fwd1 = '0;
        if (zero2) fwd2 = '0;
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb_rd
            assign bus.rd_data1 = reset ? '0 : fwd1;
            assign bus.rd_data2 = reset ? '0 : fwd2;
        end else begin : g_reg_rd
            logic [WIDTH-1:0] rd1_q, rd2_q, rd1_d, rd2_d;

            // A registered read always sees the word as it stands after this edge's write.
            always_comb begin
                rd1_d = zero1 ? '0 : mem_d[bus.rd_addr1];
                rd2_d = zero2 ? '0 : mem_d[bus.rd_addr2];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd1_q <= '0;
                    rd2_q <= '0;
                end else begin
                    rd1_q <= rd1_d;
                    rd2_q <= rd2_d;
                end
            end

            assign bus.rd_data1 = reset ? '0 : rd1_q;
            assign bus.rd_data2 = reset ? '0 : rd2_q;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_nrw_bypass.sv
// Directed bench driving three register-file builds in lockstep: bypassed comb read,
// non-bypassed comb read, and registered read.
module tb_regfile_nrw_bypass;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    regfile_nrw_bypass_if #(.WIDTH(32), .ADDR_BITS(5)) bus_b1 ();
    regfile_nrw_bypass_if #(.WIDTH(32), .ADDR_BITS(5)) bus_b0 ();
    regfile_nrw_bypass_if #(.WIDTH(32), .ADDR_BITS(5)) bus_l1 ();

    regfile_nrw_bypass #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(1), .READ_LATENCY(0))
        u_b1 (.clk(clk), .reset(reset), .bus(bus_b1));
    regfile_nrw_bypass #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(0), .READ_LATENCY(0))
        u_b0 (.clk(clk), .reset(reset), .bus(bus_b0));
    regfile_nrw_bypass #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(0), .READ_LATENCY(1))
        u_l1 (.clk(clk), .reset(reset), .bus(bus_l1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic we, input logic [4:0] wa, input logic [3:0] be,
                          input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
        bus_b1.we = we; bus_b1.wr_addr = wa; bus_b1.wr_be = be; bus_b1.wr_data = wd;
        bus_b1.rd_addr1 = ra1; bus_b1.rd_addr2 = ra2;
        bus_b0.we = we; bus_b0.wr_addr = wa; bus_b0.wr_be = be; bus_b0.wr_data = wd;
        bus_b0.rd_addr1 = ra1; bus_b0.rd_addr2 = ra2;
        bus_l1.we = we; bus_l1.wr_addr = wa; bus_l1.wr_be = be; bus_l1.wr_data = wd;
        bus_l1.rd_addr1 = ra1; bus_l1.rd_addr2 = ra2;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b1, 5'd9, 4'hF, 32'hA5A5A5A5, 5'd9, 5'd9);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_b1_rd1", bus_b1.rd_data1, 32'h0);
        check("rst_b1_rd2", bus_b1.rd_data2, 32'h0);
        check("rst_l1_rd1", bus_l1.rd_data1, 32'h0);

        // 1: after reset every address reads zero on both ports
        next_cycle();
        reset = 1'b0;
        set_in(1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd31);
        for (int a = 0; a < 32; a++) begin
            set_in(1'b0, 5'd0, 4'h0, 32'h0, 5'(a), 5'(31 - a));
            @(negedge clk);
            check("clr_b1_rd1", bus_b1.rd_data1, 32'h0);
            check("clr_b1_rd2", bus_b1.rd_data2, 32'h0);
            check("clr_b0_rd1", bus_b0.rd_data1, 32'h0);
            check("clr_l1_rd2", bus_l1.rd_data2, 32'h0);
            next_cycle();
        end

        // 2: full-word write to r5, read back next cycle
        set_in(1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 5'd5, 5'd4);
        @(negedge clk);
        check("wr5_b1_same", bus_b1.rd_data1, 32'hDEADBEEF);
        check("wr5_b0_same", bus_b0.rd_data1, 32'h0);
        next_cycle();
        set_in(1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd4);
        @(negedge clk);
        check("r5_b1", bus_b1.rd_data1, 32'hDEADBEEF);
        check("r5_b0", bus_b0.rd_data1, 32'hDEADBEEF);
        check("r4_b0", bus_b0.rd_data2, 32'h0);
        check("r5_l1", bus_l1.rd_data1, 32'hDEADBEEF);
        check("r4_l1", bus_l1.rd_data2, 32'h0);

        // 3: partial byte-enable merge
        next_cycle();
        set_in(1'b1, 5'd5, 4'b0101, 32'h11223344, 5'd5, 5'd5);
        @(negedge clk);
        check("be_b1_same", bus_b1.rd_data1, 32'hDE22BE44);
        check("be_b0_same", bus_b0.rd_data2, 32'hDEADBEEF);
        next_cycle();
        set_in(1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd5);
        @(negedge clk);
        check("be_b0_next", bus_b0.rd_data1, 32'hDE22BE44);
        check("be_l1_next", bus_l1.rd_data2, 32'hDE22BE44);

        // we=1 with no byte enables leaves the entry untouched
        next_cycle();
        set_in(1'b1, 5'd5, 4'h0, 32'hFFFFFFFF, 5'd5, 5'd5);
        @(negedge clk);
        check("be0_b1_same", bus_b1.rd_data1, 32'hDE22BE44);
        next_cycle();
        set_in(1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd5);
        @(negedge clk);
        check("be0_b0_next", bus_b0.rd_data1, 32'hDE22BE44);

        // 4: writes to the zero entry are discarded, even through bypass
        next_cycle();
        set_in(1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 5'd0, 5'd0);
        @(negedge clk);
        check("r0_b1_same", bus_b1.rd_data1, 32'h0);
        check("r0_b1_same2", bus_b1.rd_data2, 32'h0);
        next_cycle();
        set_in(1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        check("r0_b0_next", bus_b0.rd_data1, 32'h0);
        check("r0_l1_next", bus_l1.rd_data1, 32'h0);

        // 5: same-cycle bypass on both ports versus no bypass
        next_cycle();
        set_in(1'b1, 5'd7, 4'hF, 32'hCAFEF00D, 5'd7, 5'd7);
        @(negedge clk);
        check("byp_b1_rd1", bus_b1.rd_data1, 32'hCAFEF00D);
        check("byp_b1_rd2", bus_b1.rd_data2, 32'hCAFEF00D);
        check("nobyp_b0_rd1", bus_b0.rd_data1, 32'h0);
        next_cycle();
        set_in(1'b0, 5'd0, 4'h0, 32'h0, 5'd7, 5'd7);
        @(negedge clk);
        check("nobyp_b0_next1", bus_b0.rd_data1, 32'hCAFEF00D);
        check("nobyp_b0_next2", bus_b0.rd_data2, 32'hCAFEF00D);
        check("l1_r7", bus_l1.rd_data1, 32'hCAFEF00D);

        // 6: registered read with a coincident reset drops the write
        next_cycle();
        reset = 1'b1;
        set_in(1'b1, 5'd3, 4'hF, 32'h12345678, 5'd3, 5'd7);
        @(negedge clk);
        check("rst_mid_b1", bus_b1.rd_data1, 32'h0);
        next_cycle();
        reset = 1'b0;
        set_in(1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd7);
        @(negedge clk);
        check("rst_l1_rd1", bus_l1.rd_data1, 32'h0);
        check("rst_b0_r3", bus_b0.rd_data1, 32'h0);
        check("rst_b0_r7", bus_b0.rd_data2, 32'h0);
        next_cycle();
        set_in(1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd5);
        @(negedge clk);
        check("rst_l1_r3", bus_l1.rd_data1, 32'h0);
        check("rst_b1_r5", bus_b1.rd_data2, 32'h0);

        next_cycle();
        set_in(1'b1, 5'd3, 4'hF, 32'h12345678, 5'd3, 5'd3);
        next_cycle();
        set_in(1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd0);
        @(negedge clk);
        check("lat_l1_rd1", bus_l1.rd_data1, 32'h12345678);
        check("lat_l1_rd2", bus_l1.rd_data2, 32'h12345678);
        check("lat_b0_r3", bus_b0.rd_data1, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
